// File: rtl/wb_decoder_pkg.sv
// Shared definitions for the Wishbone aperture decoder: FSM encoding,
// default error read value and error-count width.
package wb_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } dec_state_e;

  localparam logic [31:0] DEFAULT_READ_VALUE_C = 32'hBAD_FAB_AC;
  localparam int          ERR_CNT_W            = 8;

endpackage

// File: rtl/wb_timeout_counter.sv
// Watchdog for the ACTIVE state: counts enabled cycles and flags the
// cycle whose increment makes the count reach TIMEOUT.
module wb_timeout_counter #(
  parameter int TIMEOUT_CNTR_WIDTH = 3,
  parameter int TIMEOUT            = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] LIMIT = TIMEOUT_CNTR_WIDTH'(TIMEOUT);

  logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_q;
  logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_d;

  // Holds at LIMIT so the count can never wrap back under the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + TIMEOUT_CNTR_WIDTH'(1);
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_d == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_aperture_decoder.sv
// Wishbone aperture decoder: routes a bridge request to one of NUM_CH slave
// channels by address, with watchdog, error completion and error logging.
module wb_aperture_decoder
  import wb_decoder_pkg::*;
#(
  parameter int                         NUM_CH             = 4,
  parameter int                         APERWIDTH          = 17,
  parameter int                         APERSIZE           = 10,
  parameter logic [NUM_CH*APERWIDTH-1:0] BASE_ADDR_VEC     = {17'h05000, 17'h04000, 17'h01000, 17'h00000},
  parameter logic [31:0]                DEFAULT_READ_VALUE = DEFAULT_READ_VALUE_C,
  parameter int                         TIMEOUT_CNTR_WIDTH = 3,
  parameter int                         TIMEOUT            = 7
) (
  input  logic                   WBs_CLK_i,
  input  logic                   WBs_RST_i,
  input  logic [APERWIDTH-1:0]   WBs_ADR_i,
  input  logic                   WBs_CYC_i,
  input  logic                   WBs_STB_i,
  output logic [NUM_CH-1:0]      WBs_CYC_ch_o,
  input  logic [NUM_CH*32-1:0]   WBs_DAT_ch_i,
  input  logic [NUM_CH-1:0]      WBs_ACK_ch_i,
  output logic [31:0]            WBs_RD_DAT_o,
  output logic                   WBs_ACK_o,
  input  logic                   Err_Clr_i,
  output logic                   Timeout_o,
  output logic [ERR_CNT_W-1:0]   Err_Cnt_o,
  output logic [APERWIDTH-1:0]   Err_Adr_o,
  output logic [1:0]             Dbg_State_o
);

  localparam int SEL_LSB = APERSIZE + 2;
  localparam int SEL_W   = APERWIDTH - SEL_LSB;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Handshake: a request is CYC&STB seen in IDLE; the bridge sees exactly one
  // WBs_ACK_o cycle per request and must drop CYC before the next request.
  // Channel side: CYC_ch[sel] stays high until ACK_ch[sel], abort or timeout.

  dec_state_e             state_q;
  logic [IDX_W-1:0]       sel_q;
  logic [NUM_CH-1:0]      cyc_ch_q;
  logic                   ack_q;
  logic [31:0]            rd_dat_q;
  logic                   timeout_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic [ERR_CNT_W-1:0]   err_cnt_d;
  logic [APERWIDTH-1:0]   err_adr_q;

  logic                   req;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [NUM_CH-1:0]      hit_onehot;
  logic                   sel_ack;
  logic [31:0]            sel_dat;
  logic                   wd_clear;
  logic                   wd_enable;
  logic                   wd_expired;
  logic                   err_evt;

  assign req = WBs_CYC_i && WBs_STB_i;

  // Descending scan so the lowest matching channel index is the one left.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (WBs_ADR_i[APERWIDTH-1:SEL_LSB] == BASE_ADDR_VEC[i*APERWIDTH+SEL_LSB +: SEL_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    hit_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_onehot[i] = (hit_idx == IDX_W'(i));
    end
  end

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ack = WBs_ACK_ch_i[i];
        sel_dat = WBs_DAT_ch_i[i*32 +: 32];
      end
    end
  end

  assign wd_clear  = (state_q == ST_IDLE) && req && hit;
  assign wd_enable = (state_q == ST_ACTIVE);

  wb_timeout_counter #(
    .TIMEOUT_CNTR_WIDTH (TIMEOUT_CNTR_WIDTH),
    .TIMEOUT            (TIMEOUT)
  ) u_watchdog (
    .clk_i     (WBs_CLK_i),
    .rst_i     (WBs_RST_i),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // A selected ACK in the expiry cycle wins, so it masks the error.
  assign err_evt = ((state_q == ST_IDLE) && req && !hit) ||
                   ((state_q == ST_ACTIVE) && WBs_CYC_i && !sel_ack && wd_expired);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (Err_Clr_i) begin
      err_cnt_d = err_evt ? ERR_CNT_W'(1) : '0;
    end else if (err_evt && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cyc_ch_q  <= '0;
      ack_q     <= 1'b0;
      rd_dat_q  <= '0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else begin
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= err_cnt_d;
      if (err_evt) begin
        err_adr_q <= WBs_ADR_i;
      end
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (hit) begin
              sel_q    <= hit_idx;
              cyc_ch_q <= hit_onehot;
              state_q  <= ST_ACTIVE;
            end else begin
              rd_dat_q <= DEFAULT_READ_VALUE;
              ack_q    <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_ACTIVE: begin
          if (!WBs_CYC_i) begin
            cyc_ch_q <= '0;
            state_q  <= ST_IDLE;
          end else if (sel_ack) begin
            rd_dat_q <= sel_dat;
            ack_q    <= 1'b1;
            cyc_ch_q <= '0;
            state_q  <= ST_DONE;
          end else if (wd_expired) begin
            rd_dat_q  <= DEFAULT_READ_VALUE;
            ack_q     <= 1'b1;
            timeout_q <= 1'b1;
            cyc_ch_q  <= '0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!WBs_CYC_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          cyc_ch_q <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign WBs_CYC_ch_o = cyc_ch_q;
  assign WBs_ACK_o    = ack_q;
  assign WBs_RD_DAT_o = rd_dat_q;
  assign Timeout_o    = timeout_q;
  assign Err_Cnt_o    = err_cnt_q;
  assign Err_Adr_o    = err_adr_q;
  assign Dbg_State_o  = state_q;

endmodule

// File: tb/tb_wb_aperture_decoder.sv
// Bench for wb_aperture_decoder: directed scenarios then randomized
// transactions checked against an address-arithmetic reference model.
module tb_wb_aperture_decoder;
  import wb_decoder_pkg::*;

  localparam int NUM_CH = 4;
  localparam int AW     = 17;
  localparam int APSZ   = 10;
  localparam int TMO    = 7;
  localparam logic [31:0] DEF = 32'hBAD_FAB_AC;
  // ch3 deliberately shares ch0's aperture to exercise priority.
  localparam logic [NUM_CH*AW-1:0] BASES = {17'h00000, 17'h04000, 17'h01000, 17'h00000};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [AW-1:0]        adr;
  logic                 cyc;
  logic                 stb;
  logic [NUM_CH-1:0]    cyc_ch;
  logic [NUM_CH*32-1:0] dat_ch;
  logic [NUM_CH-1:0]    ack_ch;
  logic [31:0]          rd_dat;
  logic                 ack;
  logic                 err_clr;
  logic                 timeout;
  logic [7:0]           err_cnt;
  logic [AW-1:0]        err_adr;
  logic [1:0]           dbg_state;

  int checks   = 0;
  int failures = 0;
  int exp_err_cnt = 0;
  logic [AW-1:0] exp_err_adr = '0;
  int base_tab [NUM_CH] = '{'h00000, 'h01000, 'h04000, 'h00000};

  always #5 clk = ~clk;

  wb_aperture_decoder #(
    .NUM_CH             (NUM_CH),
    .APERWIDTH          (AW),
    .APERSIZE           (APSZ),
    .BASE_ADDR_VEC      (BASES),
    .DEFAULT_READ_VALUE (DEF),
    .TIMEOUT_CNTR_WIDTH (3),
    .TIMEOUT            (TMO)
  ) dut (
    .WBs_CLK_i    (clk),
    .WBs_RST_i    (rst),
    .WBs_ADR_i    (adr),
    .WBs_CYC_i    (cyc),
    .WBs_STB_i    (stb),
    .WBs_CYC_ch_o (cyc_ch),
    .WBs_DAT_ch_i (dat_ch),
    .WBs_ACK_ch_i (ack_ch),
    .WBs_RD_DAT_o (rd_dat),
    .WBs_ACK_o    (ack),
    .Err_Clr_i    (err_clr),
    .Timeout_o    (timeout),
    .Err_Cnt_o    (err_cnt),
    .Err_Adr_o    (err_adr),
    .Dbg_State_o  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lowest-index channel whose aperture-sized block contains the address.
  function automatic int ref_channel(input logic [AW-1:0] a);
    int aper;
    aper = 1 << (APSZ + 2);
    for (int i = 0; i < NUM_CH; i++) begin
      if ((int'(a) / aper) == (base_tab[i] / aper)) return i;
    end
    return -1;
  endfunction

  task automatic model_err(input logic [AW-1:0] a, input bit clr);
    if (clr) exp_err_cnt = 1;
    else if (exp_err_cnt < 255) exp_err_cnt++;
    exp_err_adr = a;
  endtask

  // ack_at: ACTIVE cycle (1-based) in which the selected channel ACKs;
  // values outside 1..TMO mean it never ACKs. spur: channel ACKing spuriously.
  task automatic run_txn(input logic [AW-1:0] addr, input int ack_at, input int spur,
                         input bit clr_on_err, input logic [31:0] fixed_dat);
    int ch;
    int term;
    bit tmo;
    logic [31:0] dat [NUM_CH];
    ch = ref_channel(addr);
    for (int i = 0; i < NUM_CH; i++) begin
      dat[i] = $urandom;
      if (i == ch && fixed_dat != 0) dat[i] = fixed_dat;
      dat_ch[i*32 +: 32] = dat[i];
    end
    adr = addr;
    cyc = 1'b1;
    stb = 1'b1;
    if (ch < 0) begin
      err_clr = clr_on_err;
      step();
      err_clr = 1'b0;
      model_err(addr, clr_on_err);
      check("unmapped_ack", 32'(ack), 32'd1);
      check("unmapped_rd", rd_dat, DEF);
      check("unmapped_cyc_ch", 32'(cyc_ch), 32'd0);
      check("unmapped_timeout", 32'(timeout), 32'd0);
    end else begin
      tmo  = !(ack_at >= 1 && ack_at <= TMO);
      term = tmo ? TMO : ack_at;
      for (int k = 1; k <= term; k++) begin
        step();
        check("active_cyc_ch", 32'(cyc_ch), 32'(1) << ch);
        check("active_no_ack", 32'(ack), 32'd0);
        ack_ch = '0;
        if (spur >= 0 && spur != ch) ack_ch[spur] = 1'b1;
        if (k == ack_at) ack_ch[ch] = 1'b1;
        if (tmo && k == term) err_clr = clr_on_err;
      end
      step();
      ack_ch  = '0;
      err_clr = 1'b0;
      if (tmo) model_err(addr, clr_on_err);
      check("done_ack", 32'(ack), 32'd1);
      check("done_rd", rd_dat, tmo ? DEF : dat[ch]);
      check("done_timeout", 32'(timeout), 32'(tmo));
      check("done_cyc_ch", 32'(cyc_ch), 32'd0);
    end
    check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    check("err_adr", 32'(err_adr), 32'(exp_err_adr));
    step();
    check("hold_ack_once", 32'(ack), 32'd0);
    check("hold_timeout_once", 32'(timeout), 32'd0);
    check("hold_no_retrigger", 32'(cyc_ch), 32'd0);
    check("hold_state_done", 32'(dbg_state), 32'(ST_DONE));
    cyc = 1'b0;
    stb = 1'b0;
    step();
    check("back_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    logic [AW-1:0] ra;
    rst = 1'b1; adr = '0; cyc = 1'b0; stb = 1'b0;
    dat_ch = '0; ack_ch = '0; err_clr = 1'b0;
    step();
    step();
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_cyc_ch", 32'(cyc_ch), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rd", rd_dat, 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_err_adr", 32'(err_adr), 32'd0);
    rst = 1'b0;
    step();

    run_txn(17'h04008, 3, -1, 1'b0, 32'hA5A5_0001);
    run_txn(17'h02000, 0, -1, 1'b0, 32'd0);
    run_txn(17'h01004, 0, -1, 1'b0, 32'd0);
    run_txn(17'h01010, 7, -1, 1'b0, 32'h1234_5678);
    run_txn(17'h00100, 2, 3, 1'b0, 32'hC0DE_0000);

    // Abort: CYC dropped while the channel is selected.
    adr = 17'h04010; cyc = 1'b1; stb = 1'b1;
    step();
    check("abort_cyc_ch", 32'(cyc_ch), 32'h4);
    step();
    cyc = 1'b0; stb = 1'b0;
    step();
    check("abort_cyc_ch_off", 32'(cyc_ch), 32'd0);
    check("abort_no_ack", 32'(ack), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check("abort_no_late_ack", 32'(ack), 32'd0);

    // Reset while ACTIVE drops the transfer and clears everything.
    adr = 17'h01000; cyc = 1'b1; stb = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    exp_err_cnt = 0; exp_err_adr = '0;
    check("rst_act_cyc_ch", 32'(cyc_ch), 32'd0);
    check("rst_act_ack", 32'(ack), 32'd0);
    check("rst_act_rd", rd_dat, 32'd0);
    check("rst_act_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_act_err_adr", 32'(err_adr), 32'd0);
    step();
    check("rst_act_no_ack", 32'(ack), 32'd0);

    for (int n = 0; n < 260; n++) begin
      run_txn(17'h02000 + AW'($urandom_range(0, 'h1FFF)), 0, -1, 1'b0, 32'd0);
    end
    check("err_cnt_saturated", 32'(err_cnt), 32'hFF);
    run_txn(17'h03004, 0, -1, 1'b1, 32'd0);
    check("clr_with_err", 32'(err_cnt), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err_cnt = 0;
    check("clr_alone", 32'(err_cnt), 32'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        ra = AW'(base_tab[$urandom_range(0, NUM_CH-1)] + $urandom_range(0, 4095));
      else
        ra = AW'($urandom_range(0, 'h1FFFF));
      run_txn(ra, $urandom_range(1, 9), $urandom_range(0, NUM_CH) - 1,
              ($urandom_range(0, 3) == 0), 32'd0);
      if ($urandom_range(0, 7) == 0) begin
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err_cnt = 0;
        check("rand_clr_alone", 32'(err_cnt), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
